// File: rtl/cache_arb_pkg.sv
// Shared types for the cache refill memory-port arbiter: request sources,
// the registered memory request and the per-ID ownership entry.
package cache_arb_pkg;

    localparam int unsigned ARB_TID_W  = 2;
    localparam int unsigned ARB_ADDR_W = 64;
    localparam int unsigned ARB_DATA_W = 64;
    localparam int unsigned ARB_LINE_W = 128;

    typedef enum logic {
        SRC_ICACHE = 1'b0,
        SRC_DCACHE = 1'b1
    } arb_src_e;

    typedef struct packed {
        logic [ARB_TID_W-1:0]    tid;
        logic                    we;
        logic [ARB_ADDR_W-1:0]   addr;
        logic [ARB_DATA_W-1:0]   wdata;
        logic [ARB_DATA_W/8-1:0] be;
    } mem_req_t;

    typedef struct packed {
        logic     valid;
        arb_src_e owner;
    } tid_entry_t;

    function automatic arb_src_e other_src(arb_src_e src);
        return (src == SRC_ICACHE) ? SRC_DCACHE : SRC_ICACHE;
    endfunction

endpackage

// File: rtl/cache_arb_tid_table.sv
// Outstanding transaction-ID table: allocates the lowest free ID, records its
// owner, and looks up / retires IDs as responses return.
module cache_arb_tid_table
    import cache_arb_pkg::*;
#(
    parameter int unsigned TidWidth = ARB_TID_W
) (
    input  logic                clk_i,
    input  logic                rst_ni,
    input  logic                alloc_i,
    input  arb_src_e            alloc_owner_i,
    output logic [TidWidth-1:0] alloc_tid_o,
    output logic                full_o,
    output logic                empty_o,
    input  logic                lookup_valid_i,
    input  logic [TidWidth-1:0] lookup_tid_i,
    output logic                lookup_hit_o,
    output arb_src_e            lookup_owner_o
);

    localparam int unsigned NumIds = 2 ** TidWidth;

    tid_entry_t [NumIds-1:0] table_q;
    tid_entry_t              lookup_entry;
    logic                    found_free;
    logic                    any_valid;

    // Encoder works on registered state only, so an ID retired this cycle
    // cannot be handed out again until the next one.
    always_comb begin
        alloc_tid_o = '0;
        found_free  = 1'b0;
        any_valid   = 1'b0;
        for (int i = 0; i < int'(NumIds); i++) begin
            if (table_q[i].valid) begin
                any_valid = 1'b1;
            end else if (!found_free) begin
                alloc_tid_o = TidWidth'(i);
                found_free  = 1'b1;
            end
        end
    end

    assign full_o  = !found_free;
    assign empty_o = !any_valid;

    assign lookup_entry   = table_q[lookup_tid_i];
    assign lookup_hit_o   = lookup_valid_i && lookup_entry.valid;
    assign lookup_owner_o = lookup_entry.owner;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            table_q <= '0;
        end else begin
            if (lookup_hit_o) begin
                table_q[lookup_tid_i].valid <= 1'b0;
            end
            if (alloc_i) begin
                table_q[alloc_tid_o].valid <= 1'b1;
                table_q[alloc_tid_o].owner <= alloc_owner_i;
            end
        end
    end

endmodule

// File: rtl/cache_mem_arbiter.sv
// Round-robin arbiter sharing one refill memory port between icache and
// dcache, tagging each request with an ID and routing responses back by owner.
module cache_mem_arbiter
    import cache_arb_pkg::*;
#(
    parameter int unsigned TidWidth  = ARB_TID_W,
    parameter int unsigned AddrWidth = ARB_ADDR_W,
    parameter int unsigned DataWidth = ARB_DATA_W,
    parameter int unsigned LineWidth = ARB_LINE_W
) (
    input  logic                   clk_i,
    input  logic                   rst_ni,
    input  logic                   flush_i,
    output logic                   idle_o,
    output logic                   err_o,

    input  logic                   ic_req_valid_i,
    output logic                   ic_req_ready_o,
    input  logic [AddrWidth-1:0]   ic_req_addr_i,

    input  logic                   dc_req_valid_i,
    output logic                   dc_req_ready_o,
    input  logic                   dc_req_we_i,
    input  logic [AddrWidth-1:0]   dc_req_addr_i,
    input  logic [DataWidth-1:0]   dc_req_wdata_i,
    input  logic [DataWidth/8-1:0] dc_req_be_i,

    output logic                   mem_req_valid_o,
    input  logic                   mem_req_ready_i,
    output logic [TidWidth-1:0]    mem_req_tid_o,
    output logic                   mem_req_we_o,
    output logic [AddrWidth-1:0]   mem_req_addr_o,
    output logic [DataWidth-1:0]   mem_req_wdata_o,
    output logic [DataWidth/8-1:0] mem_req_be_o,

    input  logic                   mem_rsp_valid_i,
    input  logic [TidWidth-1:0]    mem_rsp_tid_i,
    input  logic [LineWidth-1:0]   mem_rsp_data_i,

    output logic                   ic_rsp_valid_o,
    output logic                   dc_rsp_valid_o,
    output logic [LineWidth-1:0]   rsp_data_o
);

    logic          out_valid_q;
    mem_req_t      out_q;
    mem_req_t      out_d;
    arb_src_e      prio_q;
    logic          err_q;

    logic          out_free;
    logic          can_accept;
    logic          grant_ic;
    logic          grant_dc;
    logic          accept;
    arb_src_e      grant_src;

    logic [TidWidth-1:0] alloc_tid;
    logic          tbl_full;
    logic          tbl_empty;
    logic          rsp_hit;
    arb_src_e      rsp_owner;

    cache_arb_tid_table #(
        .TidWidth (TidWidth)
    ) u_tid_table (
        .clk_i          (clk_i),
        .rst_ni         (rst_ni),
        .alloc_i        (accept),
        .alloc_owner_i  (grant_src),
        .alloc_tid_o    (alloc_tid),
        .full_o         (tbl_full),
        .empty_o        (tbl_empty),
        .lookup_valid_i (mem_rsp_valid_i),
        .lookup_tid_i   (mem_rsp_tid_i),
        .lookup_hit_o   (rsp_hit),
        .lookup_owner_o (rsp_owner)
    );

    // The output register may be reloaded in the same cycle memory takes it.
    assign out_free   = !out_valid_q || mem_req_ready_i;
    assign can_accept = out_free && !tbl_full && !flush_i;

    always_comb begin
        grant_ic = 1'b0;
        grant_dc = 1'b0;
        if (can_accept) begin
            if (ic_req_valid_i && (!dc_req_valid_i || prio_q == SRC_ICACHE)) begin
                grant_ic = 1'b1;
            end else if (dc_req_valid_i) begin
                grant_dc = 1'b1;
            end
        end
    end

    assign accept         = grant_ic || grant_dc;
    assign grant_src      = grant_dc ? SRC_DCACHE : SRC_ICACHE;
    assign ic_req_ready_o = grant_ic;
    assign dc_req_ready_o = grant_dc;

    always_comb begin
        out_d     = '0;
        out_d.tid = alloc_tid;
        if (grant_dc) begin
            out_d.we    = dc_req_we_i;
            out_d.addr  = dc_req_addr_i;
            out_d.wdata = dc_req_wdata_i;
            out_d.be    = dc_req_be_i;
        end else begin
            out_d.addr  = ic_req_addr_i;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            out_valid_q <= 1'b0;
            out_q       <= '0;
            prio_q      <= SRC_ICACHE;
            err_q       <= 1'b0;
        end else begin
            if (accept) begin
                out_valid_q <= 1'b1;
                out_q       <= out_d;
                prio_q      <= other_src(grant_src);
            end else if (mem_req_ready_i) begin
                out_valid_q <= 1'b0;
            end
            if (mem_rsp_valid_i && !rsp_hit) begin
                err_q <= 1'b1;
            end
        end
    end

    assign mem_req_valid_o = out_valid_q;
    assign mem_req_tid_o   = out_q.tid;
    assign mem_req_we_o    = out_q.we;
    assign mem_req_addr_o  = out_q.addr;
    assign mem_req_wdata_o = out_q.wdata;
    assign mem_req_be_o    = out_q.be;

    assign ic_rsp_valid_o = rsp_hit && (rsp_owner == SRC_ICACHE);
    assign dc_rsp_valid_o = rsp_hit && (rsp_owner == SRC_DCACHE);
    assign rsp_data_o     = mem_rsp_data_i;

    assign idle_o = tbl_empty && !out_valid_q;
    assign err_o  = err_q;

endmodule
